// File: rtl/loop_buffer_drain_intel_pkg.sv
// Shared definitions for the loop-buffer drain: FSM encoding, clog2 and
// skid-depth legality check.
package loop_buffer_drain_intel_pkg;

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if ((1 << r) < v) r++;
    return r;
  endfunction

  // The skid must absorb every read already in flight when m_ready drops.
  function automatic bit skid_depth_ok(input int depth, input int lat);
    return (lat >= 1) && (depth >= lat + 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/loop_buffer_drain_intel_drain_skid_fifo.sv
// Synchronous FIFO whose head is always a flop, so m_data/m_last come
// straight from storage and never from the write path.
module drain_skid_fifo
  import loop_buffer_drain_intel_pkg::*;
#(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             pop;

  assign valid   = (count != '0);
  assign rd_data = mem[rd_ptr];
  assign pop     = rd_en && valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/loop_buffer_drain_intel.sv
// Drains whole blocks from a loop buffer into a credit-limited skid FIFO,
// tagging each block with its info word until its last word is accepted.
module loop_buffer_drain_intel
  import loop_buffer_drain_intel_pkg::*;
#(
  parameter int RDATA_WIDTH  = 64,
  parameter int RADDR_WIDTH  = 8,
  parameter int READ_LATENCY = 3,
  parameter int INFO_WIDTH   = 256,
  parameter int SKID_DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [RADDR_WIDTH-1:0] rd_addr,
  input  logic [RDATA_WIDTH-1:0] rd_data,
  input  logic                   rd_vld,
  input  logic [INFO_WIDTH-1:0]  rd_info,
  output logic                   rd_rdy,
  output logic [RDATA_WIDTH-1:0] m_data,
  output logic                   m_valid,
  output logic                   m_last,
  output logic [INFO_WIDTH-1:0]  m_info,
  input  logic                   m_ready
);
  localparam int CW = clog2(SKID_DEPTH) + 1;
  localparam logic [RADDR_WIDTH-1:0] ADDR_MAX = '1;

  if (!skid_depth_ok(SKID_DEPTH, READ_LATENCY)) begin : g_bad_skid_depth
    $error("SKID_DEPTH must be a power of 2 and >= READ_LATENCY+2");
  end

  state_e                  state, state_nxt;
  logic [RADDR_WIDTH-1:0]  addr;
  logic [CW-1:0]           outstanding;
  logic                    credit, issue, start, last_issue, pop;
  logic [READ_LATENCY:0]   vld_pipe, last_pipe;
  logic [READ_LATENCY-1:0] vld_q, last_q;
  logic [RDATA_WIDTH:0]    fifo_head;
  logic [INFO_WIDTH-1:0]   info_q [2];
  logic                    info_wr, info_rd;
  logic [1:0]              info_cnt;

  // Outstanding counts both in-flight reads and FIFO contents, so the FIFO
  // can never be asked to take more than it holds.
  assign credit     = (outstanding < CW'(SKID_DEPTH));
  assign last_issue = issue && (addr == ADDR_MAX);
  assign rd_rdy     = last_issue;
  assign rd_addr    = addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE: if (rd_vld && (info_cnt != 2'd2)) begin
        start     = 1'b1;
        state_nxt = READ;
      end
      READ: if (credit) begin
        issue = 1'b1;
        if (addr == ADDR_MAX) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        addr <= '0;
    else if (start) addr <= '0;
    else if (issue) addr <= addr + RADDR_WIDTH'(1);
  end

  assign vld_pipe  = {vld_q, issue};
  assign last_pipe = {last_q, last_issue};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q  <= vld_pipe[READ_LATENCY-1:0];
      last_q <= last_pipe[READ_LATENCY-1:0];
    end
  end

  drain_skid_fifo #(.WIDTH(RDATA_WIDTH + 1), .DEPTH(SKID_DEPTH)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (vld_pipe[READ_LATENCY]),
    .wr_data ({last_pipe[READ_LATENCY], rd_data}),
    .rd_en   (m_ready),
    .rd_data (fifo_head),
    .valid   (m_valid)
  );

  assign {m_last, m_data} = fifo_head;
  assign pop              = m_valid && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) outstanding <= '0;
    else case ({issue, pop})
      2'b10:   outstanding <= outstanding + CW'(1);
      2'b01:   outstanding <= outstanding - CW'(1);
      default: outstanding <= outstanding;
    endcase
  end

  // Two entries let the next block start issuing while the previous block's
  // tail is still draining through the skid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      info_q[0] <= '0;
      info_q[1] <= '0;
      info_wr   <= 1'b0;
      info_rd   <= 1'b0;
      info_cnt  <= '0;
    end else begin
      if (start) begin
        info_q[info_wr] <= rd_info;
        info_wr         <= ~info_wr;
      end
      if (pop && m_last) info_rd <= ~info_rd;
      case ({start, pop && m_last})
        2'b10:   info_cnt <= info_cnt + 2'd1;
        2'b01:   info_cnt <= info_cnt - 2'd1;
        default: info_cnt <= info_cnt;
      endcase
    end
  end

  assign m_info = info_q[info_rd];

endmodule

// File: tb/tb_loop_buffer_drain_intel.sv
// Directed bench for loop_buffer_drain_intel with 8-word blocks: a cycle
// table for a single block, then hand-written multi-block / stall / reset runs.
module tb_loop_buffer_drain_intel;
  localparam int DW = 8, AW = 3, LAT = 3, IW = 8, SD = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_vld;
  logic [IW-1:0] rd_info;
  logic          rd_rdy;
  logic [DW-1:0] m_data;
  logic          m_valid, m_last;
  logic [IW-1:0] m_info;
  logic          m_ready = 1'b0;

  loop_buffer_drain_intel #(
    .RDATA_WIDTH(DW), .RADDR_WIDTH(AW), .READ_LATENCY(LAT),
    .INFO_WIDTH(IW), .SKID_DEPTH(SD)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_vld(rd_vld), .rd_info(rd_info), .rd_rdy(rd_rdy),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_info(m_info), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // Upstream loop buffer: holds (added - released) blocks; block b word k
  // reads back as {b[3:0], 1'b0, k}, returned LAT cycles after the address.
  int            added = 0;
  int            released;
  logic [DW-1:0] dly [LAT];

  assign rd_vld  = (added != released);
  assign rd_info = 8'h0A + 8'(released);
  assign rd_data = dly[LAT-1];

  always @(posedge clk) begin
    if (rst) released <= 0;
    else if (rd_rdy) released <= released + 1;
    dly[0] <= {4'(released), 1'b0, rd_addr};
    for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
  end

  int n_cmp = 0, n_bad = 0;
  int exp_idx, rdy_cnt, max_out, cyc, first_cyc, last_cyc;
  logic prev_rdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_word(input int idx);
    logic [3:0] b;
    logic [2:0] k;
    b = 4'(idx / 8);
    k = 3'(idx % 8);
    return {b, 1'b0, k};
  endfunction

  // One cycle: drive m_ready at the negedge, then check the settled outputs.
  task automatic tick(input logic rdy);
    @(negedge clk);
    m_ready = rdy;
    #1;
    cyc++;
    if (rd_rdy) begin
      rdy_cnt++;
      chk("rdy_with_vld", rd_vld, 1'b1);
      chk("rdy_back_to_back", prev_rdy, 1'b0);
    end
    prev_rdy = rd_rdy;
    if (int'(dut.outstanding) > max_out) max_out = int'(dut.outstanding);
    if (m_valid && m_ready) begin
      chk("word_data", m_data, exp_word(exp_idx));
      chk("word_last", m_last, (exp_idx % 8) == 7);
      chk("word_info", m_info, 8'h0A + 8'(exp_idx / 8));
      if (exp_idx == 0) first_cyc = cyc;
      last_cyc = cyc;
      exp_idx++;
    end
  endtask

  task automatic drain(input int target, input int budget, input bit rnd);
    int n;
    n = 0;
    while (exp_idx < target && n < budget) begin
      tick(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      n++;
    end
    if (exp_idx < target) chk("drain_timeout", exp_idx, target);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_ready = 1'b0;
    added = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_idx = 0; rdy_cnt = 0; max_out = 0; cyc = 0;
    first_cyc = 0; last_cyc = 0; prev_rdy = 1'b0;
  endtask

  typedef struct {
    logic          rdy;
    logic [AW-1:0] addr;
    logic          rrdy;
    logic          mv;
    logic [DW-1:0] data;
    logic          last;
  } vec_t;
  vec_t vec [14];

  initial begin
    // Single block, m_ready high: issue c1..c8, words out c5..c12.
    vec[0]  = '{1'b1, 3'd0, 1'b0, 1'b0, 8'd0, 1'b0};
    vec[1]  = '{1'b1, 3'd0, 1'b0, 1'b0, 8'd0, 1'b0};
    vec[2]  = '{1'b1, 3'd1, 1'b0, 1'b0, 8'd0, 1'b0};
    vec[3]  = '{1'b1, 3'd2, 1'b0, 1'b0, 8'd0, 1'b0};
    vec[4]  = '{1'b1, 3'd3, 1'b0, 1'b0, 8'd0, 1'b0};
    vec[5]  = '{1'b1, 3'd4, 1'b0, 1'b1, 8'd0, 1'b0};
    vec[6]  = '{1'b1, 3'd5, 1'b0, 1'b1, 8'd1, 1'b0};
    vec[7]  = '{1'b1, 3'd6, 1'b0, 1'b1, 8'd2, 1'b0};
    vec[8]  = '{1'b1, 3'd7, 1'b1, 1'b1, 8'd3, 1'b0};
    vec[9]  = '{1'b1, 3'd0, 1'b0, 1'b1, 8'd4, 1'b0};
    vec[10] = '{1'b1, 3'd0, 1'b0, 1'b1, 8'd5, 1'b0};
    vec[11] = '{1'b1, 3'd0, 1'b0, 1'b1, 8'd6, 1'b0};
    vec[12] = '{1'b1, 3'd0, 1'b0, 1'b1, 8'd7, 1'b1};
    vec[13] = '{1'b1, 3'd0, 1'b0, 1'b0, 8'd0, 1'b0};

    @(negedge clk);
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_rd_rdy", rd_rdy, 1'b0);
    chk("rst_rd_addr", rd_addr, 3'd0);
    chk("rst_m_data", m_data, 8'd0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_m_info", m_info, 8'd0);

    do_reset();
    added = 1;
    for (int i = 0; i < 14; i++) begin
      m_ready = vec[i].rdy;
      #1;
      chk($sformatf("tbl%0d_rd_addr", i), rd_addr, vec[i].addr);
      chk($sformatf("tbl%0d_rd_rdy", i), rd_rdy, vec[i].rrdy);
      chk($sformatf("tbl%0d_m_valid", i), m_valid, vec[i].mv);
      if (vec[i].mv) begin
        chk($sformatf("tbl%0d_m_data", i), m_data, vec[i].data);
        chk($sformatf("tbl%0d_m_last", i), m_last, vec[i].last);
        chk($sformatf("tbl%0d_m_info", i), m_info, 8'h0A);
      end
      @(negedge clk);
    end

    // Two queued blocks: 16 words with exactly one bubble between blocks.
    do_reset();
    added = 2;
    drain(16, 80, 1'b0);
    chk("two_blk_span", last_cyc - first_cyc, 16);
    chk("two_blk_rdy_cnt", rdy_cnt, 2);

    // Backpressure from cycle 0: credit stops the second block at address 0.
    do_reset();
    added = 2;
    for (int i = 0; i < 24; i++) begin
      tick(1'b0);
      if (m_valid) chk("stall_head_stable", m_data, 8'd0);
    end
    chk("stall_m_valid", m_valid, 1'b1);
    chk("stall_rd_addr", rd_addr, 3'd0);
    chk("stall_rdy_cnt", rdy_cnt, 1);
    chk("stall_outstanding", dut.outstanding, 4'd8);
    drain(16, 100, 1'b0);
    chk("stall_rdy_cnt_end", rdy_cnt, 2);

    // Random 50% m_ready over four blocks.
    do_reset();
    added = 4;
    drain(32, 1000, 1'b1);
    chk("rand_rdy_cnt", rdy_cnt, 4);
    chk("rand_outstanding_bound", max_out <= SD, 1'b1);

    // Reset after three words: everything dropped, next block restarts at 0.
    do_reset();
    added = 2;
    drain(3, 40, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_m_valid", m_valid, 1'b0);
    chk("midrst_rd_rdy", rd_rdy, 1'b0);
    chk("midrst_rd_addr", rd_addr, 3'd0);
    chk("midrst_no_partial_rdy", rdy_cnt, 0);
    chk("midrst_state", dut.state, 1'b0);
    do_reset();
    added = 1;
    drain(8, 60, 1'b0);
    chk("midrst_new_blk_rdy", rdy_cnt, 1);
    repeat (4) tick(1'b1);
    chk("midrst_no_extra_words", exp_idx, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/loop_buffer_drain_intel.md
LOOP_BUFFER_DRAIN_INTEL -- requirements
Module: loop_buffer_drain_intel

Interface
REQ-001 Parameters (name, default, meaning): RDATA_WIDTH, 64, read word width; RADDR_WIDTH, 8, in-block address width, block = 2**RADDR_WIDTH words; READ_LATENCY, 3, RAM address-to-data cycles; INFO_WIDTH, 256, block info width; SKID_DEPTH, 8, output FIFO entries, power of 2, >= READ_LATENCY+2.
REQ-002 Ports (name direction width meaning): clk in 1 clock; rst in 1 reset, asynchronous, active-high; one clock only.
REQ-003 rd_addr out RADDR_WIDTH in-block read address to loop buffer; rd_data in RDATA_WIDTH RAM data, valid READ_LATENCY cycles after address.
REQ-004 rd_vld in 1 at least one complete block held; rd_info in INFO_WIDTH head-block info, valid while rd_vld; rd_rdy out 1 one-cycle block-release pulse.
REQ-005 m_data out RDATA_WIDTH, m_valid out 1, m_last out 1 final word of block, m_info out INFO_WIDTH block info, m_ready in 1 downstream accept.

Function
REQ-006 FSM states IDLE, READ; reset state IDLE.
REQ-007 IDLE->READ when rd_vld=1 and info queue not full; same cycle, rd_info captured into 2-entry info queue and address counter cleared to 0.
REQ-008 In READ, one address issued per cycle when credit available; credit available when outstanding < SKID_DEPTH (outstanding = in-flight reads + FIFO occupancy); no credit -> rd_addr held, no issue.
REQ-009 Address counter increments by 1 per issue; issue of address 2**RADDR_WIDTH-1 asserts rd_rdy in that same cycle, returns FSM to IDLE, counter wraps to 0.
REQ-010 rd_rdy asserted only in that cycle and only with rd_vld=1; never two cycles in a row; back-to-back blocks: IDLE lasts exactly one cycle when rd_vld remains 1.
REQ-011 Issue pipeline: READ_LATENCY-stage shift register of {issue, last}; at stage output, rd_data and last flag written to skid FIFO.
REQ-012 Outstanding counter: +1 on issue, -1 on m_valid&m_ready, net 0 on both; width clog2(SKID_DEPTH)+1; must never exceed SKID_DEPTH -> FIFO never overflows.
REQ-013 m_valid = FIFO not empty; m_data/m_last from FIFO head; stable while m_valid=1 and m_ready=0.
REQ-014 m_info = info queue head; info queue popped on m_valid&m_ready&m_last.
REQ-015 Throughput: with m_ready=1 continuously, one word per cycle sustained; block start to first m_valid = READ_LATENCY+2 cycles from rd_vld rising in IDLE.
REQ-016 Word order within a block: m_data word k = RAM word at address k, k = 0..2**RADDR_WIDTH-1; exactly one m_last per block.

Reset
REQ-017 rst asynchronous assert, synchronous release; on assert: FSM IDLE, rd_addr 0, rd_rdy 0, m_valid 0, m_last 0, m_data 0, m_info 0, counters 0, pipeline and both queues empty.
REQ-018 rst mid-block discards all in-flight and buffered words; no rd_rdy emitted for partial block; upstream loop buffer reset together with this block.

Structure
REQ-019 Shared package: FSM state encoding, clog2 function, SKID_DEPTH legality constant check.
REQ-020 One sub-module: drain_skid_fifo (synchronous, registered-output, width RDATA_WIDTH+1, depth SKID_DEPTH); info queue and issue pipeline inline.

Verification
REQ-021 RADDR_WIDTH=3, one block of data 0..7, m_ready=1 -> m_data 0..7 consecutive cycles, m_last on 7, one rd_rdy pulse on issue of addr 7.
REQ-022 Two blocks queued (rd_vld held), info 0xA then 0xB, m_ready=1 -> 16 words gap-free except single IDLE cycle bubble, m_info 0xA for first 8 words, 0xB for next 8.
REQ-023 m_ready=0 from cycle 0 -> issue stops after SKID_DEPTH=8 addresses, m_valid=1, m_data=word0 stable; m_ready=1 -> remaining words in order, no loss/duplication.
REQ-024 m_ready random 50% over 4 blocks -> output sequence equals RAM model, outstanding never >8, rd_rdy count = 4.
REQ-025 rst asserted after 3 words output -> next cycle m_valid=0, rd_rdy=0, FSM IDLE; after release with rd_vld=1 -> new block starts at address 0.
